// File: rtl/rwt_adc_pattern_pkg.sv
// ---------------------------------------------------------------------------
// rwt_adc_pattern_pkg
// Shared types and helpers for the ADC pattern source:
//   mode_e      - pattern selector (CONST / RAMP / PRBS / TOGGLE)
//   state_e     - run state (IDLE / RUN)
//   PRBS_*      - PRBS-31 length and tap positions (x^31 + x^28 + 1)
//   prbs_init   - seed fixup (all-zero state would lock the LFSR)
//   prbs_step   - one Fibonacci shift of the PRBS-31 register
// ---------------------------------------------------------------------------
package rwt_adc_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CONST  = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_PRBS   = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int PRBS_LEN    = 31;
  localparam int PRBS_TAP_HI = 30;  // x^31 term
  localparam int PRBS_TAP_LO = 27;  // x^28 term

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
  function automatic logic [PRBS_LEN-1:0] prbs_init(input logic [PRBS_LEN-1:0] s);
    return (s == '0) ? {{(PRBS_LEN-1){1'b0}}, 1'b1} : s;
  endfunction

  function automatic logic [PRBS_LEN-1:0] prbs_step(input logic [PRBS_LEN-1:0] s);
    return {s[PRBS_LEN-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/rwt_adc_rate_div.sv
// ---------------------------------------------------------------------------
// rwt_adc_rate_div
// Sample-rate down-counter. clear loads the counter with period; while
// enable is high the counter runs down and reloads, and strobe is high in
// every cycle where the count has reached zero. strobe therefore marks the
// clock edges on which the parent emits a sample; the parent emits the very
// first sample of a run itself on the clear edge.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - reload counter with period (start of run)
//   enable    - counter runs while high
//   period    - cycles between strobes minus 1
//   strobe    - one-cycle strobe, emit a sample on this edge
// ---------------------------------------------------------------------------
module rwt_adc_rate_div #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 strobe
);

  logic [DIV_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= period;
    end else if (enable) begin
      if (cnt_reg == '0) begin
        cnt_reg <= period;
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign strobe = enable && !clear && (cnt_reg == '0);

endmodule

// File: rtl/rwt_adc_pattern_source.sv
// ---------------------------------------------------------------------------
// rwt_adc_pattern_source
// Test-pattern generator driving the ADC stream interface in place of a
// real ADC front-end. A start pulse latches the configuration and begins a
// run; samples are emitted every rate_div+1 cycles until num_samples have
// been sent (0 = run until stop).
//
// Optional feature macro: RWT_ADC_PATTERN_PRBS_EN
//   defined   -> PRBS-31 generator present, mode 2 = PRBS
//   undefined -> no LFSR, mode 2 behaves exactly as CONST
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start, stop   - one-cycle run control pulses
//   mode          - 0 CONST, 1 RAMP, 2 PRBS, 3 TOGGLE
//   rate_div      - sample period minus 1, in clk cycles
//   num_samples   - samples per run, 0 = continuous
//   enable_mask   - channels enabled for the run
//   seed          - pattern seed / base value
//   adc_data      - channel i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   adc_enable    - latched enable_mask while busy
//   adc_valid     - per-channel valid on strobe cycles
//   busy          - high while running
//   done          - one-cycle pulse when a run ends (completion or stop)
//   samples_sent  - samples emitted in the current / last run
// ---------------------------------------------------------------------------
module rwt_adc_pattern_source
  import rwt_adc_pattern_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DIV_WIDTH    = 16,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic [1:0]                           mode,
  input  logic [DIV_WIDTH-1:0]                 rate_div,
  input  logic [COUNT_WIDTH-1:0]               num_samples,
  input  logic [NUM_CHANNELS-1:0]              enable_mask,
  input  logic [SAMPLE_WIDTH-1:0]              seed,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] adc_data,
  output logic [NUM_CHANNELS-1:0]              adc_enable,
  output logic [NUM_CHANNELS-1:0]              adc_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic [COUNT_WIDTH-1:0]               samples_sent
);

  // -------------------------------------------------------------------------
  // State and latched configuration
  // -------------------------------------------------------------------------
  state_e                            state_reg;
  mode_e                             mode_reg;
  logic [SAMPLE_WIDTH-1:0]           seed_reg;
  logic [COUNT_WIDTH-1:0]            num_reg;
  logic [DIV_WIDTH-1:0]              rate_div_reg;
  logic [NUM_CHANNELS-1:0]           enable_reg;
  logic [NUM_CHANNELS-1:0]           valid_reg;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] data_reg;
  logic                              busy_reg;
  logic                              done_reg;
  logic [COUNT_WIDTH-1:0]            sent_reg;

  logic start_fire;
  logic run_end;
  logic div_strobe;

  // start is only honoured from IDLE; a start in RUN is dropped.
  assign start_fire = (state_reg == ST_IDLE) && start;

  // The final strobe is already on the outputs when sent_reg reaches the
  // target, so the run closes on the edge after it. stop closes it too.
  assign run_end = stop || ((num_reg != '0) && (sent_reg == num_reg));

  // -------------------------------------------------------------------------
  // Rate divider. On the start edge the divider is loaded straight from the
  // input port because rate_div_reg is only being written on that edge.
  // -------------------------------------------------------------------------
  rwt_adc_rate_div #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_rate_div (
    .clk   (clk),
    .rst   (rst),
    .clear (start_fire),
    .enable(state_reg == ST_RUN),
    .period(start_fire ? rate_div : rate_div_reg),
    .strobe(div_strobe)
  );

  // -------------------------------------------------------------------------
  // Pattern operands for the sample about to be emitted. On the start edge
  // sample 0 is built from the raw inputs; afterwards from the latched copy.
  // sent_reg doubles as the index of the next sample.
  // -------------------------------------------------------------------------
  mode_e                   mode_cur;
  logic [SAMPLE_WIDTH-1:0] seed_cur;
  logic [SAMPLE_WIDTH-1:0] n_cur;
  logic [NUM_CHANNELS-1:0] mask_cur;

  assign mode_cur = start_fire ? mode_e'(mode) : mode_reg;
  assign seed_cur = start_fire ? seed : seed_reg;
  assign n_cur    = start_fire ? '0 : SAMPLE_WIDTH'(sent_reg);
  assign mask_cur = start_fire ? enable_mask : enable_reg;

`ifdef RWT_ADC_PATTERN_PRBS_EN
  // lfsr_reg holds the state for the next sample (state after n shifts).
  logic [PRBS_LEN-1:0] lfsr_reg;
  logic [PRBS_LEN-1:0] lfsr_cur;

  assign lfsr_cur = start_fire ? prbs_init(PRBS_LEN'(seed)) : lfsr_reg;
`endif

  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [SAMPLE_WIDTH-1:0] ch_val;

`ifdef RWT_ADC_PATTERN_PRBS_EN
      // Each channel taps the LFSR rotated left by 3*i bits.
      localparam int ROT = (3 * gi) % PRBS_LEN;
      logic [PRBS_LEN-1:0] prbs_rot;

      if (ROT == 0) begin : g_rot0
        assign prbs_rot = lfsr_cur;
      end else begin : g_rotn
        assign prbs_rot = (lfsr_cur << ROT) | (lfsr_cur >> (PRBS_LEN - ROT));
      end
`endif

      always_comb begin
        ch_val = seed_cur;
        case (mode_cur)
          MODE_RAMP:   ch_val = seed_cur + n_cur + SAMPLE_WIDTH'(gi);
          MODE_TOGGLE: ch_val = n_cur[0] ? ~seed_cur : seed_cur;
`ifdef RWT_ADC_PATTERN_PRBS_EN
          MODE_PRBS:   ch_val = prbs_rot[SAMPLE_WIDTH-1:0];
`endif
          default:     ch_val = seed_cur;
        endcase
      end

      // Disabled channels are held at zero regardless of pattern.
      assign sample_next[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = mask_cur[gi] ? ch_val : '0;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Main control: single registered FSM driving every output.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= MODE_CONST;
      seed_reg     <= '0;
      num_reg      <= '0;
      rate_div_reg <= '0;
      enable_reg   <= '0;
      valid_reg    <= '0;
      data_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sent_reg     <= '0;
`ifdef RWT_ADC_PATTERN_PRBS_EN
      lfsr_reg     <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // start beats a coincident stop: stop is not looked at in IDLE.
          if (start) begin
            state_reg    <= ST_RUN;
            mode_reg     <= mode_e'(mode);
            seed_reg     <= seed;
            num_reg      <= num_samples;
            rate_div_reg <= rate_div;
            enable_reg   <= enable_mask;
            busy_reg     <= 1'b1;
            // Sample 0 goes out on this same edge.
            data_reg     <= sample_next;
            valid_reg    <= enable_mask;
            sent_reg     <= COUNT_WIDTH'(1);
`ifdef RWT_ADC_PATTERN_PRBS_EN
            lfsr_reg     <= prbs_step(lfsr_cur);
`endif
          end
        end
        ST_RUN: begin
          if (run_end) begin
            state_reg  <= ST_IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            enable_reg <= '0;
            valid_reg  <= '0;
            data_reg   <= '0;
          end else if (div_strobe) begin
            data_reg  <= sample_next;
            valid_reg <= enable_reg;
            sent_reg  <= sent_reg + 1'b1;
`ifdef RWT_ADC_PATTERN_PRBS_EN
            lfsr_reg  <= prbs_step(lfsr_cur);
`endif
          end else begin
            valid_reg <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign adc_data     = data_reg;
  assign adc_enable   = enable_reg;
  assign adc_valid    = valid_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign samples_sent = sent_reg;

endmodule

// File: tb/tb_rwt_adc_pattern_source.sv
// ---------------------------------------------------------------------------
// tb_rwt_adc_pattern_source
// Self-checking bench for rwt_adc_pattern_source (4 channels x 16 bits).
// A behavioural model derives every output from the run parameters and the
// cycle count since start; a compare process checks the DUT against it each
// cycle, and directed scenarios pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rwt_adc_pattern_source;

  localparam int NC = 4;
  localparam int SW = 16;
  localparam int DW = 16;
  localparam int CW = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic           stop;
  logic [1:0]     mode;
  logic [DW-1:0]  rate_div;
  logic [CW-1:0]  num_samples;
  logic [NC-1:0]  enable_mask;
  logic [SW-1:0]  seed;
  logic [NC*SW-1:0] adc_data;
  logic [NC-1:0]  adc_enable;
  logic [NC-1:0]  adc_valid;
  logic           busy;
  logic           done;
  logic [CW-1:0]  samples_sent;

  rwt_adc_pattern_source #(
    .NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW), .DIV_WIDTH(DW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .rate_div(rate_div), .num_samples(num_samples), .enable_mask(enable_mask),
    .seed(seed), .adc_data(adc_data), .adc_enable(adc_enable),
    .adc_valid(adc_valid), .busy(busy), .done(done), .samples_sent(samples_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] getch(input int i);
    return adc_data[i*SW +: SW];
  endfunction

  // ---------------- behavioural model ----------------
  // Pattern value of channel ch for sample n of a run.
  function automatic logic [SW-1:0] exp_sample(input int md, input logic [SW-1:0] sd,
                                               input int n, input int ch);
    logic [30:0] s;
    logic [30:0] r;
    case (md)
      1: return sd + SW'(n) + SW'(ch);
      3: return (n % 2 == 1) ? ~sd : sd;
      2: begin
`ifdef RWT_ADC_PATTERN_PRBS_EN
        s = 31'(sd);
        if (s == 0) s = 31'd1;
        for (int k = 0; k < n; k++) s = {s[29:0], s[30] ^ s[27]};
        r = '0;
        for (int b = 0; b < 31; b++) r[(b + 3*ch) % 31] = s[b];
        return r[SW-1:0];
`else
        s = '0;
        r = s;
        return sd;
`endif
      end
      default: return sd;
    endcase
  endfunction

  bit            m_busy = 0;
  bit            m_done = 0;
  logic [NC-1:0] m_valid = '0;
  logic [NC-1:0] m_enable = '0;
  logic [NC*SW-1:0] m_data = '0;
  longint        m_sent = 0;
  int            m_k = 0;
  int            m_mode, m_rd, m_n;
  longint        m_N;
  logic [SW-1:0] m_seed;

  task automatic m_emit(input int n);
    for (int i = 0; i < NC; i++)
      m_data[i*SW +: SW] = m_enable[i] ? exp_sample(m_mode, m_seed, n, i) : '0;
    m_valid = m_enable;
    m_sent  = n + 1;
  endtask

  // Model advances on each edge: what will the outputs be in the next cycle?
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_valid = '0; m_enable = '0; m_data = '0;
      m_sent = 0; m_k = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        m_valid = '0;
        if (start) begin
          m_mode = int'(mode); m_rd = int'(rate_div); m_N = longint'(num_samples);
          m_enable = enable_mask; m_seed = seed; m_busy = 1; m_k = 1;
          m_emit(0);
        end
      end else if (stop || (m_N != 0 && m_sent == m_N)) begin
        m_busy = 0; m_done = 1; m_valid = '0; m_enable = '0; m_data = '0;
      end else begin
        m_k++;
        if ((m_k - 1) % (m_rd + 1) == 0) begin
          m_n = (m_k - 1) / (m_rd + 1);
          m_emit(m_n);
        end else begin
          m_valid = '0;
        end
      end
    end
  end

  // Compare process: every cycle out of reset.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("m_busy", 64'(busy), 64'(m_busy));
      check("m_done", 64'(done), 64'(m_done));
      check("m_enable", 64'(adc_enable), 64'(m_enable));
      check("m_valid", 64'(adc_valid), 64'(m_valid));
      check("m_sent", 64'(samples_sent), 64'(m_sent));
      check("m_data", 64'(adc_data), 64'(m_data));
    end
  end

  // ---------------- stimulus ----------------
  task automatic adv(input int c);
    repeat (c) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of cycle T+1.
  task automatic go(input int md, input int rd, input int n, input int msk, input int sd);
    mode = 2'(md); rate_div = DW'(rd); num_samples = CW'(n);
    enable_mask = NC'(msk); seed = SW'(sd); start = 1'b1;
    adv(1);
    start = 1'b0;
    $display("TXN start mode=%0d rate_div=%0d num=%0d mask=%h seed=%h", md, rd, n, msk, SW'(sd));
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = budget;
    while (busy && b > 0) begin adv(1); b--; end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
    adv(1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 0; stop = 0; mode = 0; rate_div = 0; num_samples = 0;
    enable_mask = 0; seed = 0;
    adv(3);
    rst = 1'b0;
    adv(1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sent", 64'(samples_sent), 64'd0);
    check("rst_data", 64'(adc_data), 64'd0);

    // CONST, 3 samples back-to-back
    go(0, 0, 3, 4'hF, 16'h1234);
    check("const_ch0", 64'(getch(0)), 64'h1234);
    check("const_ch3", 64'(getch(3)), 64'h1234);
    check("const_valid", 64'(adc_valid), 64'hF);
    adv(2);
    check("const_valid_t3", 64'(adc_valid), 64'hF);
    adv(1);
    check("const_done", 64'(done), 64'd1);
    check("const_valid_t4", 64'(adc_valid), 64'd0);
    check("const_sent", 64'(samples_sent), 64'd3);
    adv(1);

    // RAMP with wrap, sparse mask, rate_div=2
    go(1, 2, 2, 4'b0101, 16'hFFFE);
    check("ramp_ch0_a", 64'(getch(0)), 64'hFFFE);
    check("ramp_ch2_a", 64'(getch(2)), 64'h0000);
    check("ramp_ch1_a", 64'(getch(1)), 64'h0000);
    check("ramp_valid_a", 64'(adc_valid), 64'h5);
    adv(1);
    check("ramp_gap_valid", 64'(adc_valid), 64'h0);
    adv(2);
    check("ramp_ch0_b", 64'(getch(0)), 64'hFFFF);
    check("ramp_ch2_b", 64'(getch(2)), 64'h0001);
    adv(1);
    check("ramp_done", 64'(done), 64'd1);
    adv(1);

    // PRBS continuous, then stop at T+10
    go(2, 0, 0, 4'hF, 16'h0001);
    check("prbs_ch0_0", 64'(getch(0)), 64'h0001);
    adv(1);
`ifdef RWT_ADC_PATTERN_PRBS_EN
    check("prbs_ch0_1", 64'(getch(0)), 64'h0002);
    adv(1);
    check("prbs_ch0_2", 64'(getch(0)), 64'h0004);
`else
    check("prbs_ch0_1", 64'(getch(0)), 64'h0001);
    adv(1);
    check("prbs_ch0_2", 64'(getch(0)), 64'h0001);
`endif
    adv(7);
    stop = 1'b1;
    adv(1);
    stop = 1'b0;
    check("stop_done", 64'(done), 64'd1);
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_data", 64'(adc_data), 64'd0);
    adv(1);

    // TOGGLE, second start while busy ignored
    go(3, 0, 0, 4'hF, 16'h00FF);
    check("tog_a", 64'(getch(1)), 64'h00FF);
    mode = 2'd0; seed = 16'h1234; start = 1'b1;
    adv(1);
    start = 1'b0;
    check("tog_b", 64'(getch(1)), 64'hFF00);
    adv(1);
    check("tog_c", 64'(getch(1)), 64'h00FF);
    stop = 1'b1;
    adv(1);
    stop = 1'b0;
    adv(1);

    // mode 2 with seed 0x0AAA
    go(2, 0, 1, 4'hF, 16'h0AAA);
    check("m2_ch0", 64'(getch(0)), 64'h0AAA);
`ifdef RWT_ADC_PATTERN_PRBS_EN
    check("m2_ch1", 64'(getch(1)), 64'h5550);
`else
    check("m2_ch1", 64'(getch(1)), 64'h0AAA);
`endif
    adv(2);

    // Reset at the third strobe, then restart from n=0
    go(0, 0, 0, 4'hF, 16'h55AA);
    adv(2);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_valid", 64'(adc_valid), 64'd0);
    check("rst_mid_data", 64'(adc_data), 64'd0);
    check("rst_mid_sent", 64'(samples_sent), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    adv(1);
    go(1, 0, 2, 4'h1, 16'h0000);
    check("restart_ch0", 64'(getch(0)), 64'h0000);
    check("restart_sent", 64'(samples_sent), 64'd1);
    adv(1);
    check("restart_ch0_b", 64'(getch(0)), 64'h0001);
    adv(2);

    // Randomized runs
    for (int t = 0; t < 30; t++) begin
      int r;
      stop = ($urandom_range(0, 3) == 0);
      go($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5),
         $urandom_range(0, 15), int'($urandom));
      stop = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (!busy) break;
        r = $urandom_range(0, 19);
        if (r == 0) stop = 1'b1;
        else if (r == 1) begin start = 1'b1; seed = SW'($urandom); end
        adv(1);
        stop = 1'b0; start = 1'b0;
      end
      if (busy) begin stop = 1'b1; adv(1); stop = 1'b0; end
      wait_idle(5);
      adv($urandom_range(0, 2));
    end

    adv(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rwt_adc_pattern_source.md
Name: rwt_adc_pattern_source

Overview:
Synthesizable, parametrised ADC-side sample source that drives the standard ADC stream interface (adc_data/adc_enable/adc_valid) with generated test patterns at a programmable sample rate. Sits in place of a real ADC front-end on the ADC capture path, giving hardware and simulation a deterministic, self-checkable stimulus. Generalises the fixed 16-bit, file-driven source to arbitrary channel count and sample width, with pattern modes, rate division and bounded or continuous runs.

Parameters:
NUM_CHANNELS, 4, number of channels; range 1..16
SAMPLE_WIDTH, 16, bits per channel sample; range 4..31
DIV_WIDTH, 16, width of rate divider
COUNT_WIDTH, 32, width of sample counters

Ports:
clk  in  1  single clock; all logic synchronous to it
rst  in  1  reset, asynchronous assert, active-high
start  in  1  one-cycle pulse; begin a run (latches all config inputs)
stop  in  1  one-cycle pulse; abort run
mode  in  2  0 CONST, 1 RAMP, 2 PRBS, 3 TOGGLE
rate_div  in  DIV_WIDTH  sample period minus 1, in clk cycles
num_samples  in  COUNT_WIDTH  samples per run; 0 = continuous
enable_mask  in  NUM_CHANNELS  channels enabled for the run
seed  in  SAMPLE_WIDTH  pattern seed/base value
adc_data  out  NUM_CHANNELS*SAMPLE_WIDTH  channel i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
adc_enable  out  NUM_CHANNELS  latched enable_mask while busy
adc_valid  out  NUM_CHANNELS  per-channel valid = strobe AND adc_enable
busy  out  1  high in RUN
done  out  1  one-cycle pulse on run completion or abort
samples_sent  out  COUNT_WIDTH  samples emitted in current/last run

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, config registers 0.
- States: IDLE, RUN. IDLE->RUN on start. RUN->IDLE on stop, or in the cycle after the num_samples-th strobe when num_samples != 0.
- start sampled in cycle T: config latched, samples_sent cleared, div counter cleared; busy=1 and first strobe at T+1; then strobe every rate_div+1 cycles (rate_div=0 -> every cycle).
- start while busy: ignored. stop while IDLE: ignored. start and stop in same IDLE cycle: start wins.
- All outputs registered. adc_data updates only on strobe cycles and holds between them; disabled channels are always 0.
- samples_sent increments on each strobe; wraps modulo 2^COUNT_WIDTH in continuous mode.
- done: 1-cycle pulse in the cycle after the final strobe (adc_valid=0 that cycle) or the cycle after stop. On return to IDLE: adc_data, adc_enable, adc_valid, busy all 0; samples_sent holds.
- stop coinciding with the final strobe: that strobe is emitted, single done pulse.
- Patterns (sample index n counted from 0 per run, arithmetic modulo 2^SAMPLE_WIDTH):
  CONST: ch i = seed.
  RAMP: ch i = seed + n + i.
  TOGGLE: ch i = seed for even n, ~seed for odd n.
  PRBS: 31-bit Fibonacci LFSR, x^31+x^28+1; init = zero-extended seed, forced to 1 if 0; sample n uses state after n shifts (shift: {s[29:0], s[30]^s[27]}); ch i = rotate_left(state, 3*i)[SAMPLE_WIDTH-1:0].
- rst asserted mid-run: immediate return to reset values, no done pulse.

Optional Feature:
RWT_ADC_PATTERN_PRBS_EN: defined -> PRBS mode and LFSR present as above. Undefined -> LFSR removed; mode 2 behaves exactly as CONST.

Decomposition:
- Package rwt_adc_pattern_pkg: mode enum (CONST/RAMP/PRBS/TOGGLE), state enum, PRBS-31 tap constants and init-fixup function.
- Sub-module rwt_adc_rate_div: DIV_WIDTH down-counter; clear input; one-cycle strobe output.

Test Plan:
- CONST, seed=0x1234, mask=4'b1111, rate_div=0, num_samples=3 -> adc_valid high cycles T+1..T+3 on all channels, each ch=0x1234; done at T+4; samples_sent=3.
- RAMP, seed=0xFFFE, mask=4'b0101, rate_div=2, num_samples=2 -> strobes T+1, T+4; ch0=0xFFFE then 0xFFFF; ch2=0x0000 then 0x0001; ch1/ch3=0 with adc_valid=0; done at T+5.
- PRBS, seed=1, continuous, rate_div=0 -> ch0 sequence 0x0001, 0x0002, 0x0004; stop at T+10 -> done T+11, busy=0, outputs 0.
- TOGGLE, seed=0x00FF, num_samples=0 -> ch values alternate 0x00FF/0xFF00; second start while busy ignored.
- Reset mid-run at third strobe -> all outputs 0 immediately, no done; new start after reset restarts at n=0.
- Macro undefined, mode=2, seed=0x0AAA -> every ch=0x0AAA.
